alu_resp_checker: RTL and testbench

Synthesizable response checker for the 32-bit ALU: the reader side of the ALU stimulus interface. A vector source hands it expected result and flags over a valid/ready handshake as it applies operands to the ALU. The checker waits a fixed settle time, then samples the ALU's `result`/`zero`/`cout`/`overflow` and compares them under a per-vector flag mask. It keeps pass/fail statistics and captures the first failing vector, for on-chip self-test and for checking benches.

---
 rtl/alu_chk_pkg.sv | 19 +
 rtl/alu_chk_cmp.sv | 23 ++
 rtl/alu_resp_checker.sv | 131 +++++++++++++
 tb/tb_alu_resp_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU response checker.
// The FSM state type, flag bit positions and default widths live here.
package alu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } chk_state_e;

  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/alu_chk_cmp.sv
// Combinational compare of an ALU observation against an expected vector.
// The result is always compared; each flag is compared only where its mask bit is set.
module alu_chk_cmp
  import alu_chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] exp_result,
  input  logic [2:0]        exp_flags,
  input  logic [2:0]        flag_mask,
  input  logic [DATA_W-1:0] obs_result,
  input  logic [2:0]        obs_flags,
  output logic              mismatch
);

  logic       res_diff;
  logic [2:0] flg_diff;

  assign res_diff = (obs_result != exp_result);
  assign flg_diff = (obs_flags ^ exp_flags) & flag_mask;
  assign mismatch = res_diff | (|flg_diff);

endmodule

// File: rtl/alu_resp_checker.sv
// Reader side of the ALU stimulus interface: accepts expected vectors, waits a settle
// time, compares the ALU outputs and keeps pass/fail statistics plus the first failure.
module alu_resp_checker
  import alu_chk_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_result,
  input  logic [2:0]        exp_flags,
  input  logic [2:0]        flag_mask,
  input  logic              exp_last,
  input  logic [DATA_W-1:0] obs_result,
  input  logic              obs_zero,
  input  logic              obs_cout,
  input  logic              obs_overflow,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_result,
  output logic [2:0]        first_err_flags,
  output logic              busy,
  output logic              done,
  output logic              any_err
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  chk_state_e        state;
  logic [SC_W-1:0]   settle_cnt;
  logic [DATA_W-1:0] exp_result_p0;
  logic [2:0]        exp_flags_p0;
  logic [2:0]        mask_p0;
  logic              last_p0;
  logic [2:0]        obs_flags;
  logic              accept;
  logic              sample;
  logic              mismatch;

  assign obs_flags[FLG_Z] = obs_zero;
  assign obs_flags[FLG_C] = obs_cout;
  assign obs_flags[FLG_V] = obs_overflow;

  assign accept    = (state == WAIT) && exp_valid;
  assign sample    = (state == SETTLE) && (settle_cnt == '0);
  assign exp_ready = (state == WAIT);
  assign busy      = (state == WAIT) || (state == SETTLE);
  assign done      = (state == DONE);
  assign any_err   = (err_cnt != '0);

  // Stage p0: expected vector captured at accept, held through the settle window
  always_ff @(posedge clk) begin
    if (accept) begin
      exp_result_p0 <= exp_result;
      exp_flags_p0  <= exp_flags;
      mask_p0       <= flag_mask;
      last_p0       <= exp_last;
    end
  end

  alu_chk_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .exp_result(exp_result_p0),
    .exp_flags (exp_flags_p0),
    .flag_mask (mask_p0),
    .obs_result(obs_result),
    .obs_flags (obs_flags),
    .mismatch  (mismatch)
  );

  // Control and statistics; start is only honoured while not running a vector stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      vec_cnt          <= '0;
      err_cnt          <= '0;
      first_err_idx    <= '0;
      first_err_result <= '0;
      first_err_flags  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_cnt          <= '0;
            err_cnt          <= '0;
            first_err_idx    <= '0;
            first_err_result <= '0;
            first_err_flags  <= '0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (accept) begin
            settle_cnt <= SC_W'(SETTLE_CYC - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!sample) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            vec_cnt <= sat_inc(vec_cnt);
            if (mismatch) begin
              err_cnt <= sat_inc(err_cnt);
              if (err_cnt == '0) begin
                first_err_idx    <= vec_cnt;
                first_err_result <= obs_result;
                first_err_flags  <= obs_flags;
              end
            end
            state <= last_p0 ? DONE : WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed-vector bench for alu_resp_checker; the bench itself plays the ALU
// by driving the obs_* inputs with hand-chosen values.
module tb_alu_resp_checker;

  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;
  localparam int SETTLE_CYC = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              exp_valid = 1'b0;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_result = '0;
  logic [2:0]        exp_flags = '0;
  logic [2:0]        flag_mask = '0;
  logic              exp_last = 1'b0;
  logic [DATA_W-1:0] obs_result = '0;
  logic [2:0]        obs_flg = '0;
  logic [CNT_W-1:0]  vec_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_result;
  logic [2:0]        first_err_flags;
  logic              busy;
  logic              done;
  logic              any_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_resp_checker #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_result      (exp_result),
    .exp_flags       (exp_flags),
    .flag_mask       (flag_mask),
    .exp_last        (exp_last),
    .obs_result      (obs_result),
    .obs_zero        (obs_flg[2]),
    .obs_cout        (obs_flg[1]),
    .obs_overflow    (obs_flg[0]),
    .vec_cnt         (vec_cnt),
    .err_cnt         (err_cnt),
    .first_err_idx   (first_err_idx),
    .first_err_result(first_err_result),
    .first_err_flags (first_err_flags),
    .busy            (busy),
    .done            (done),
    .any_err         (any_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one vector, then returns #1 after the compare edge.
  task automatic send_vec(input logic [31:0] er, input logic [2:0] ef, input logic [2:0] m,
                          input logic last, input logic [31:0] orr, input logic [2:0] of);
    int n;
    n = 0;
    @(negedge clk);
    exp_valid  = 1'b1;
    exp_result = er;
    exp_flags  = ef;
    flag_mask  = m;
    exp_last   = last;
    obs_result = orr;
    obs_flg    = of;
    while (!exp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!exp_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      exp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_valid  = 1'b0;
    exp_result = ~er;
    exp_flags  = ~ef;
    flag_mask  = ~m;
    exp_last   = ~last;
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("rst_ready", 32'(exp_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // 1: AND ffff0000 & 0000ffff = 0, zero flag only compared
    pulse_start();
    chk("t1_ready_after_start", 32'(exp_ready), 32'd1);
    send_vec(32'h0000_0000, 3'b100, 3'b100, 1'b1, 32'h0000_0000, 3'b100);
    chk("t1_vec_cnt", 32'(vec_cnt), 32'd1);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ready_done", 32'(exp_ready), 32'd0);

    // 2a: ffffffff + 1 = 0 with z and c, all flags compared
    pulse_start();
    send_vec(32'h0000_0000, 3'b110, 3'b111, 1'b1, 32'h0000_0000, 3'b110);
    chk("t2a_err_cnt", 32'(err_cnt), 32'd0);
    chk("t2a_any_err", 32'(any_err), 32'd0);
    // 2b: same vector, ALU cout stuck at 0
    pulse_start();
    send_vec(32'h0000_0000, 3'b110, 3'b111, 1'b1, 32'h0000_0000, 3'b100);
    chk("t2b_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2b_first_idx", 32'(first_err_idx), 32'd0);
    chk("t2b_first_flags", 32'(first_err_flags), 32'b100);
    chk("t2b_first_result", first_err_result, 32'h0000_0000);

    // 3: four vectors, results of 1 and 3 wrong
    pulse_start();
    send_vec(32'h0000_0011, 3'b000, 3'b000, 1'b0, 32'h0000_0011, 3'b000);
    chk("t3_not_done", 32'(done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    send_vec(32'h0000_0022, 3'b000, 3'b000, 1'b0, 32'h0000_dead, 3'b000);
    send_vec(32'h0000_0033, 3'b000, 3'b000, 1'b0, 32'h0000_0033, 3'b000);
    send_vec(32'h0000_0044, 3'b000, 3'b000, 1'b1, 32'h0000_beef, 3'b000);
    chk("t3_vec_cnt", 32'(vec_cnt), 32'd4);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);
    chk("t3_first_idx", 32'(first_err_idx), 32'd1);
    chk("t3_first_result", first_err_result, 32'h0000_dead);
    chk("t3_any_err", 32'(any_err), 32'd1);

    // 4: overflow mismatch masked out
    pulse_start();
    send_vec(32'h0000_0005, 3'b001, 3'b110, 1'b1, 32'h0000_0005, 3'b000);
    chk("t4_err_cnt", 32'(err_cnt), 32'd0);
    chk("t4_vec_cnt", 32'(vec_cnt), 32'd1);

    // 5: saturation of 4-bit counters over 20 failing vectors
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      send_vec(32'(i), 3'b000, 3'b000, (i == 19), 32'(i) ^ 32'h8000_0000, 3'b000);
    end
    chk("t5_vec_sat", 32'(vec_cnt), 32'hf);
    chk("t5_err_sat", 32'(err_cnt), 32'hf);
    chk("t5_first_idx", 32'(first_err_idx), 32'd0);
    chk("t5_done", 32'(done), 32'd1);
    pulse_start();
    chk("t5_clr_vec", 32'(vec_cnt), 32'd0);
    chk("t5_clr_err", 32'(err_cnt), 32'd0);
    chk("t5_clr_any", 32'(any_err), 32'd0);
    chk("t5_clr_done", 32'(done), 32'd0);

    // 6: vector 1 fails, reset pulsed during SETTLE of vector 2
    send_vec(32'h0000_0001, 3'b000, 3'b000, 1'b0, 32'h0000_00f1, 3'b010);
    chk("t6_pre_err", 32'(err_cnt), 32'd1);
    @(negedge clk);
    exp_valid  = 1'b1;
    exp_result = 32'h0000_0007;
    exp_last   = 1'b0;
    flag_mask  = 3'b000;
    obs_result = 32'h0000_0007;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    chk("t6_settle_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vec", 32'(vec_cnt), 32'd0);
    chk("t6_rst_err", 32'(err_cnt), 32'd0);
    chk("t6_rst_first_res", first_err_result, 32'd0);
    chk("t6_rst_first_flg", 32'(first_err_flags), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_any", 32'(any_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_ready", 32'(exp_ready), 32'd0);
    chk("t6_idle_vec", 32'(vec_cnt), 32'd0);

    // start with exp_valid in IDLE: vector taken in the following WAIT cycle
    start      = 1'b1;
    exp_valid  = 1'b1;
    exp_result = 32'h0000_0009;
    exp_flags  = 3'b000;
    flag_mask  = 3'b000;
    exp_last   = 1'b0;
    obs_result = 32'h0000_0009;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t6_wait_not_taken", 32'(exp_ready), 32'd1);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    chk("t6_taken", 32'(exp_ready), 32'd0);
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
    chk("t6_vec_after", 32'(vec_cnt), 32'd1);

    // start during WAIT is ignored
    pulse_start();
    chk("t6_start_wait_vec", 32'(vec_cnt), 32'd1);
    chk("t6_start_wait_ready", 32'(exp_ready), 32'd1);
    send_vec(32'h0000_000a, 3'b000, 3'b000, 1'b1, 32'h0000_000a, 3'b000);
    chk("t6_final_vec", 32'(vec_cnt), 32'd2);
    chk("t6_final_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
